bus_initiator: RTL and testbench
================================

BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter TIMEOUT, default 255, bus-strobe cycles allowed before abort; 0 disables timeout.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command request present.
REQ-005 cmd_ready  output  1  block accepts command this cycle.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  byte address.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 cmd_wmask  input  4  per-byte write enable.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  consumer takes response.
REQ-012 rsp_rdata  output  32  read data (0 for writes and errors).
REQ-013 rsp_error  output  2  00 OK, 01 misaligned, 10 timeout.
REQ-014 bus_addr, bus_wdata, bus_wmask  output  32/32/4  peripheral bus address, data, mask.
REQ-015 bus_wen, bus_ren  output  1/1  peripheral bus strobes.
REQ-016 bus_rdata  input  32  peripheral read data, valid while bus_ready high.
REQ-017 bus_ready  input  1  peripheral done; may be combinationally high in the same cycle as the strobe.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; cmd_ready SHALL be 1 only in IDLE, decoded from the state register (no combinational path from rsp_ready).
REQ-019 Accept at edge T when IDLE and cmd_valid; cmd_addr/wdata/wmask/write SHALL be registered onto bus_addr/bus_wdata/bus_wmask and the operation type.
REQ-020 Aligned accept (cmd_addr[1:0]==0) SHALL enter ACCESS; bus_wen (write) or bus_ren (read) SHALL be high from cycle T+1.
REQ-021 Misaligned accept SHALL go directly to RESP with no strobe, rsp_error=01, rsp_rdata=0, rsp_valid high in cycle T+1.
REQ-022 In ACCESS, on a cycle with bus_ready=1 the block SHALL capture bus_rdata (reads) or 0 (writes), set rsp_error=00, and enter RESP; strobe SHALL be low the next cycle, so an always-ready peripheral sees exactly one strobe cycle.
REQ-023 Timeout counter SHALL clear at accept and count ACCESS cycles without bus_ready; after TIMEOUT strobe cycles without bus_ready, strobe SHALL drop and RESP SHALL be entered with rsp_error=10, rsp_rdata=0.
REQ-024 bus_ready high in the final permitted cycle SHALL win over timeout.
REQ-025 bus_wen and bus_ren SHALL never be high together and SHALL be low outside ACCESS.
REQ-026 bus_addr/bus_wdata/bus_wmask SHALL hold their values outside ACCESS until the next accept.
REQ-027 In RESP, rsp_valid=1 and rsp_rdata/rsp_error SHALL be stable until rsp_ready; on rsp_valid&rsp_ready return to IDLE next cycle (minimum 3-cycle issue interval for aligned, always-ready access).
REQ-028 cmd_wmask==0 writes SHALL still issue a one-strobe bus transaction.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, cmd_ready=1 after release, rsp_valid=0, strobes=0, and bus_addr, bus_wdata, bus_wmask, rsp_rdata, rsp_error and the counter to 0, including when asserted mid-ACCESS or mid-RESP.

Structure
REQ-030 Package bus_pkg SHALL hold the state enum and the rsp_error code constants (ERR_OK, ERR_MISALIGN, ERR_TIMEOUT).
REQ-031 Timeout counting SHALL live in one sub-module bus_timeout_ctr (clear, enable, expired output, width $clog2(TIMEOUT+1)).

Verification
REQ-032 Write addr 0xA004, data 0x000000FF, mask 0xF, bus_ready tied 1 -> bus_wen high exactly at T+1, rsp_valid at T+2, rsp_error 00, rsp_rdata 0.
REQ-033 Read addr 0xA008, responder returns 0x00001234 with ready 1 -> bus_ren one cycle, rsp_rdata 0x00001234, rsp_error 00.
REQ-034 Read with bus_ready held low 3 strobe cycles then high -> bus_ren high 4 cycles, correct rdata, no error.
REQ-035 TIMEOUT=8, bus_ready tied 0 -> strobe high exactly 8 cycles, rsp_error 10, rsp_rdata 0.
REQ-036 Addr 0xA002 -> no strobe, rsp_valid at T+1 with rsp_error 01; hold rsp_ready low 5 cycles -> response stable, cmd_ready 0.
REQ-037 rst_n asserted during ACCESS -> strobes low without a clock edge, rsp_valid 0, next command accepted normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus initiator.
package bus_pkg;

    // Initiator control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Response error codes reported on rsp_error.
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    // Only word-aligned addresses are issued to the peripheral bus.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Counts bus-strobe cycles that saw no bus_ready. 'expired' flags the
// final permitted strobe cycle (still without ready), so the initiator
// can abort at the end of exactly TIMEOUT strobe cycles. TIMEOUT=0 never expires.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [W-1:0] count_reg;

    // Counter: cleared at command accept, advances on each unready strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + W'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
            assign expired = enable && (count_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/bus_initiator.sv
// Command-to-peripheral-bus initiator: accepts one command, drives a single
// strobe phase until bus_ready or timeout, then holds the response until taken.
module bus_initiator
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_error,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    output logic        bus_wen,
    output logic        bus_ren,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  wmask_reg, wmask_next;
    logic        write_reg, write_next;
    logic [31:0] rdata_reg, rdata_next;
    logic [1:0]  error_reg, error_next;
    logic        accept;
    logic        tmo_enable;
    logic        tmo_expired;

    assign accept     = (state_reg == ST_IDLE) && cmd_valid;
    assign tmo_enable = (state_reg == ST_ACCESS) && !bus_ready;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wmask_reg <= '0;
            write_reg <= 1'b0;
            rdata_reg <= '0;
            error_reg <= ERR_OK;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wmask_reg <= wmask_next;
            write_reg <= write_next;
            rdata_reg <= rdata_next;
            error_reg <= error_next;
        end
    end

    // Next-state and datapath update; bus_ready is checked before timeout so
    // a ready in the final permitted cycle completes normally.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wmask_next = wmask_reg;
        write_next = write_reg;
        rdata_next = rdata_reg;
        error_next = error_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_next  = cmd_addr;
                    wdata_next = cmd_wdata;
                    wmask_next = cmd_wmask;
                    write_next = cmd_write;
                    rdata_next = '0;
                    if (is_aligned(cmd_addr)) begin
                        error_next = ERR_OK;
                        state_next = ST_ACCESS;
                    end else begin
                        error_next = ERR_MISALIGN;
                        state_next = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                if (bus_ready) begin
                    rdata_next = write_reg ? 32'h0 : bus_rdata;
                    error_next = ERR_OK;
                    state_next = ST_RESP;
                end else if (tmo_expired) begin
                    rdata_next = '0;
                    error_next = ERR_TIMEOUT;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Handshakes and strobes decode straight from the state register.
    assign cmd_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign bus_wen   = (state_reg == ST_ACCESS) && write_reg;
    assign bus_ren   = (state_reg == ST_ACCESS) && !write_reg;
    assign bus_addr  = addr_reg;
    assign bus_wdata = wdata_reg;
    assign bus_wmask = wmask_reg;
    assign rsp_rdata = rdata_reg;
    assign rsp_error = error_reg;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed self-checking bench for bus_initiator (TIMEOUT=8).
module tb_bus_initiator;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_error;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_wen;
    logic        bus_ren;
    logic [31:0] bus_rdata = '0;
    logic        bus_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int n;

    bus_initiator #(
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wmask (cmd_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wmask (bus_wmask),
        .bus_wen   (bus_wen),
        .bus_ren   (bus_ren),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present a command at a falling edge; returns at the falling edge of cycle T+1.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wmask);
        check("cmd_ready_before_accept", cmd_ready, 1);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wmask = wmask;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'hBAD0BAD0;
        cmd_wmask = 4'h0;
        $display("issue wr=%0d addr=0x%08h wdata=0x%08h wmask=0x%h", wr, addr, wdata, wmask);
    endtask

    // Count strobe cycles; bus_ready is raised on strobe cycle ready_after+1
    // (ready_after < 0: never). Bounded so a stuck strobe still terminates.
    task automatic strobe_run(input int ready_after, output int cnt);
        cnt = 0;
        for (int i = 0; i < 40 && (bus_wen || bus_ren); i++) begin
            cnt++;
            check("strobe_exclusive", {31'b0, bus_wen & bus_ren}, 0);
            bus_ready = (ready_after >= 0) && (cnt > ready_after);
            @(posedge clk);
            @(negedge clk);
        end
        bus_ready = 1'b0;
        $display("strobe cycles=%0d", cnt);
    endtask

    // Check the held response, then consume it.
    task automatic finish_rsp(input string tag, input logic [31:0] exp_rdata, input logic [1:0] exp_err, input logic [31:0] exp_addr);
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_rsp_error"}, {30'b0, rsp_error}, {30'b0, exp_err});
        check({tag, "_strobes_low"}, {30'b0, bus_wen, bus_ren}, 0);
        check({tag, "_cmd_ready_low"}, cmd_ready, 0);
        check({tag, "_addr_held"}, bus_addr, exp_addr);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_back_idle"}, {31'b0, cmd_ready}, 1);
        check({tag, "_rsp_dropped"}, rsp_valid, 0);
        $display("response %s rdata=0x%08h err=%0d", tag, exp_rdata, exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_strobes", {30'b0, bus_wen, bus_ren}, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_rsp_error", {30'b0, rsp_error}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write, always-ready peripheral: one strobe at T+1, response at T+2
        issue(1'b1, 32'h0000A004, 32'h000000FF, 4'hF);
        check("wr_wen_t1", bus_wen, 1);
        check("wr_ren_t1", bus_ren, 0);
        check("wr_bus_addr", bus_addr, 32'h0000A004);
        check("wr_bus_wdata", bus_wdata, 32'h000000FF);
        check("wr_bus_wmask", {28'b0, bus_wmask}, 32'hF);
        strobe_run(0, n);
        check("wr_strobe_cycles", n, 1);
        finish_rsp("wr", 32'h0, ERR_OK, 32'h0000A004);

        // Read, ready immediately
        bus_rdata = 32'h00001234;
        issue(1'b0, 32'h0000A008, 32'h0, 4'h0);
        check("rd_ren_t1", bus_ren, 1);
        check("rd_wen_t1", bus_wen, 0);
        strobe_run(0, n);
        check("rd_strobe_cycles", n, 1);
        finish_rsp("rd", 32'h00001234, ERR_OK, 32'h0000A008);

        // Read, ready after three wait cycles
        bus_rdata = 32'hCAFE0001;
        issue(1'b0, 32'h0000A00C, 32'h0, 4'h0);
        strobe_run(3, n);
        check("rdwait_strobe_cycles", n, 4);
        finish_rsp("rdwait", 32'hCAFE0001, ERR_OK, 32'h0000A00C);

        // Read timeout: no ready ever
        bus_rdata = 32'hDEADBEEF;
        issue(1'b0, 32'h0000A010, 32'h0, 4'h0);
        strobe_run(-1, n);
        check("tmo_strobe_cycles", n, 8);
        finish_rsp("tmo", 32'h0, ERR_TIMEOUT, 32'h0000A010);

        // Ready in the final permitted cycle beats the timeout
        issue(1'b0, 32'h0000A014, 32'h0, 4'h0);
        strobe_run(7, n);
        check("lastready_strobe_cycles", n, 8);
        finish_rsp("lastready", 32'hDEADBEEF, ERR_OK, 32'h0000A014);

        // Write timeout reports zero data
        issue(1'b1, 32'h0000A018, 32'h55AA55AA, 4'h3);
        check("wrtmo_wen_t1", bus_wen, 1);
        strobe_run(-1, n);
        check("wrtmo_strobe_cycles", n, 8);
        finish_rsp("wrtmo", 32'h0, ERR_TIMEOUT, 32'h0000A018);

        // Zero-mask write still issues one strobe
        issue(1'b1, 32'h0000A01C, 32'h12345678, 4'h0);
        check("mask0_wen_t1", bus_wen, 1);
        check("mask0_bus_wmask", {28'b0, bus_wmask}, 0);
        check("mask0_bus_wdata", bus_wdata, 32'h12345678);
        strobe_run(0, n);
        check("mask0_strobe_cycles", n, 1);
        finish_rsp("mask0", 32'h0, ERR_OK, 32'h0000A01C);

        // Misaligned: no strobe, response at T+1, held while rsp_ready low
        issue(1'b1, 32'h0000A002, 32'hFFFFFFFF, 4'hF);
        check("mis_no_strobe", {30'b0, bus_wen, bus_ren}, 0);
        check("mis_rsp_valid_t1", rsp_valid, 1);
        check("mis_rsp_error_t1", {30'b0, rsp_error}, {30'b0, ERR_MISALIGN});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("mis_hold_valid", rsp_valid, 1);
            check("mis_hold_error", {30'b0, rsp_error}, {30'b0, ERR_MISALIGN});
            check("mis_hold_cmd_ready", cmd_ready, 0);
            check("mis_hold_strobes", {30'b0, bus_wen, bus_ren}, 0);
        end
        finish_rsp("mis", 32'h0, ERR_MISALIGN, 32'h0000A002);

        // Misaligned read with nonzero bus data still returns zero
        bus_rdata = 32'h87654321;
        issue(1'b0, 32'h0000A003, 32'h0, 4'h0);
        check("misrd_no_strobe", {30'b0, bus_wen, bus_ren}, 0);
        finish_rsp("misrd", 32'h0, ERR_MISALIGN, 32'h0000A003);

        // Reset during ACCESS: strobe drops without a clock edge
        issue(1'b0, 32'h0000A020, 32'h0, 4'h0);
        check("rstacc_ren_before", bus_ren, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstacc_ren", bus_ren, 0);
        check("rstacc_wen", bus_wen, 0);
        check("rstacc_rsp_valid", rsp_valid, 0);
        check("rstacc_cmd_ready", cmd_ready, 1);
        check("rstacc_bus_addr", bus_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_rdata = 32'h00000042;
        issue(1'b0, 32'h0000A024, 32'h0, 4'h0);
        check("postrst_ren_t1", bus_ren, 1);
        strobe_run(0, n);
        check("postrst_strobe_cycles", n, 1);
        finish_rsp("postrst", 32'h00000042, ERR_OK, 32'h0000A024);

        // Reset during RESP clears the pending response
        issue(1'b0, 32'h0000A001, 32'h0, 4'h0);
        check("rstrsp_valid_before", rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstrsp_rsp_valid", rsp_valid, 0);
        check("rstrsp_rsp_error", {30'b0, rsp_error}, 0);
        check("rstrsp_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstrsp_idle_after", cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
